// File: rtl/arena_pkg.sv
// -----------------------------------------------------------------------------
// arena_pkg
// Shared definitions for the arena wall raster generator:
//   - default playfield geometry (640 x 480, 10-bit pixel, 9-bit line)
//   - thickness FSM state encoding (ST_RUN / ST_PEND)
//   - clog2 helper used to size the flash counter
// No ports (package).
// -----------------------------------------------------------------------------
package arena_pkg;

   localparam int H_ACT_DEF = 640;
   localparam int V_ACT_DEF = 480;
   localparam int X_W_DEF   = 10;
   localparam int Y_W_DEF   = 9;

   // ST_RUN : no shrink pending; ST_PEND : one shrink latched for next frame
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } thk_state_e;

   // Smallest r with 2**r >= value (value >= 1 gives r >= 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/arena_flash_timer.sv
// -----------------------------------------------------------------------------
// arena_flash_timer
// Wall-hit flash timer: a hit (re)loads the counter with FLASH_FRAMES, each
// frame_start decrements a nonzero count, flash is high while the count is
// nonzero. A hit in the same cycle as frame_start loads without decrementing.
// Ports:
//   clk           in  system clock
//   rst           in  synchronous active-high reset
//   frame_start_i in  one-cycle frame boundary pulse
//   wall_hit_i    in  one-cycle wall hit pulse
//   flash_o       out wall-colour invert request
// -----------------------------------------------------------------------------
module arena_flash_timer
   import arena_pkg::*;
#(
   parameter int FLASH_FRAMES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start_i,
   input  logic wall_hit_i,
   output logic flash_o
);

   localparam int CW = (clog2(FLASH_FRAMES + 1) < 1) ? 1 : clog2(FLASH_FRAMES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wall_hit_i) begin
         cnt_d = CW'(FLASH_FRAMES);
      end else if (frame_start_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign flash_o = (cnt_q != '0);

endmodule

// File: rtl/arena_walls.sv
// -----------------------------------------------------------------------------
// arena_walls
// Playfield border raster generator with a frame-synchronous shrinking arena
// and an optional wall-hit flash timer (enabled by defining ARENA_FLASH_EN;
// when undefined, flash is tied low and wall_hit is ignored).
// Ports:
//   clk           in  system clock (25 MHz)
//   rst           in  synchronous active-high reset
//   line          in  current line coordinate (valid 1..V_ACT)
//   pixel         in  current pixel coordinate (valid 1..H_ACT)
//   frame_start   in  one-cycle pulse per frame, during blanking
//   shrink_req    in  request thickness += THK_STEP at next frame_start
//   arena_clr     in  request thickness = THK_MIN at next frame_start
//   wall_hit      in  ball touched the wall
//   bit_raster    out coordinate is in the wall (registered)
//   bit_raster_iw out coordinate is active and inside the wall (registered)
//   flash         out wall-colour invert request
//   at_max        out thk == THK_MAX (registered)
//   thk           out current applied wall thickness
// -----------------------------------------------------------------------------
module arena_walls
   import arena_pkg::*;
#(
   parameter int H_ACT        = H_ACT_DEF,
   parameter int V_ACT        = V_ACT_DEF,
   parameter int X_W          = X_W_DEF,
   parameter int Y_W          = Y_W_DEF,
   parameter int THK_MIN      = 15,
   parameter int THK_MAX      = 120,
   parameter int THK_STEP     = 8,
   parameter int FLASH_FRAMES = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [Y_W-1:0] line,
   input  logic [X_W-1:0] pixel,
   input  logic           frame_start,
   input  logic           shrink_req,
   input  logic           arena_clr,
   input  logic           wall_hit,
   output logic           bit_raster,
   output logic           bit_raster_iw,
   output logic           flash,
   output logic           at_max,
   output logic [X_W-1:0] thk
);

   // One bit wider than the widest coordinate so pixel + thk never wraps.
   localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 1;

   thk_state_e     state_q, state_d;
   logic [X_W-1:0] thk_q, thk_d;
   logic           clr_pend_q, clr_pend_d;
   logic           at_max_q;
   logic           br_q, iw_q;

   // ---------------- raster compare ----------------
   logic [CW-1:0] px_w, ln_w, thk_w;
   logic          active, wall;

   assign px_w  = CW'(pixel);
   assign ln_w  = CW'(line);
   assign thk_w = CW'(thk_q);

   assign active = (px_w >= CW'(1)) && (px_w <= CW'(H_ACT)) &&
                   (ln_w >= CW'(1)) && (ln_w <= CW'(V_ACT));

   // "x >= N - thk + 1" rewritten as "x + thk >= N + 1" to avoid underflow.
   assign wall = (px_w <= thk_w) || ((px_w + thk_w) >= CW'(H_ACT + 1)) ||
                 (ln_w <= thk_w) || ((ln_w + thk_w) >= CW'(V_ACT + 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         br_q <= 1'b0;
         iw_q <= 1'b0;
      end else begin
         br_q <= active & wall;
         iw_q <= active & ~wall;
      end
   end

   // ---------------- thickness FSM ----------------
   logic [X_W:0] thk_sum;
   logic         shrink_acc;

   assign thk_sum    = {1'b0, thk_q} + (X_W + 1)'(THK_STEP);
   assign shrink_acc = shrink_req & ~arena_clr;  // clear beats a same-cycle shrink

   always_comb begin
      state_d    = state_q;
      thk_d      = thk_q;
      clr_pend_d = clr_pend_q;
      if (frame_start) begin
         if (clr_pend_q) begin
            thk_d = X_W'(THK_MIN);
         end else if (state_q == ST_PEND) begin
            if (thk_sum >= (X_W + 1)'(THK_MAX)) thk_d = X_W'(THK_MAX);
            else                                thk_d = thk_sum[X_W-1:0];
         end
         // Requests arriving with this frame_start wait for the next one.
         clr_pend_d = arena_clr;
         state_d    = shrink_acc ? ST_PEND : ST_RUN;
      end else begin
         if (arena_clr) clr_pend_d = 1'b1;
         unique case (state_q)
            ST_RUN:  if (shrink_acc) state_d = ST_PEND;
            ST_PEND: state_d = ST_PEND;  // further requests are dropped
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         thk_q      <= X_W'(THK_MIN);
         clr_pend_q <= 1'b0;
         at_max_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         thk_q      <= thk_d;
         clr_pend_q <= clr_pend_d;
         at_max_q   <= (thk_d == X_W'(THK_MAX));
      end
   end

   // ---------------- flash ----------------
`ifdef ARENA_FLASH_EN
   arena_flash_timer #(
      .FLASH_FRAMES(FLASH_FRAMES)
   ) u_flash (
      .clk          (clk),
      .rst          (rst),
      .frame_start_i(frame_start),
      .wall_hit_i   (wall_hit),
      .flash_o      (flash)
   );
`else
   logic unused_wall_hit;
   assign unused_wall_hit = wall_hit;
   assign flash           = 1'b0;
`endif

   assign bit_raster    = br_q;
   assign bit_raster_iw = iw_q;
   assign at_max        = at_max_q;
   assign thk           = thk_q;

endmodule

// File: tb/tb_arena_walls.sv
// -----------------------------------------------------------------------------
// tb_arena_walls
// Self-checking bench for arena_walls: a table of raster vectors, hand-written
// multi-cycle sequences, and randomized cycles compared against a behavioural
// model of thickness, pending requests and the flash count.
// -----------------------------------------------------------------------------
module tb_arena_walls;

   localparam int H_ACT    = 640;
   localparam int V_ACT    = 480;
   localparam int THK_MIN  = 15;
   localparam int THK_MAX  = 120;
   localparam int THK_STEP = 8;
   localparam int FLASH_N  = 8;
`ifdef ARENA_FLASH_EN
   localparam bit FL_EN = 1'b1;
`else
   localparam bit FL_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [8:0] line;
   logic [9:0] pixel;
   logic       frame_start, shrink_req, arena_clr, wall_hit;
   logic       bit_raster, bit_raster_iw, flash, at_max;
   logic [9:0] thk;

   arena_walls dut (
      .clk          (clk),
      .rst          (rst),
      .line         (line),
      .pixel        (pixel),
      .frame_start  (frame_start),
      .shrink_req   (shrink_req),
      .arena_clr    (arena_clr),
      .wall_hit     (wall_hit),
      .bit_raster   (bit_raster),
      .bit_raster_iw(bit_raster_iw),
      .flash        (flash),
      .at_max       (at_max),
      .thk          (thk)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #20 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_thk  = THK_MIN;
   bit m_pend = 1'b0;
   bit m_clrp = 1'b0;
   int m_fcnt = 0;

   function automatic bit in_wall(input int px, input int ln, input int t);
      return (px <= t) || (px >= H_ACT - t + 1) || (ln <= t) || (ln >= V_ACT - t + 1);
   endfunction

   function automatic bit in_active(input int px, input int ln);
      return (px >= 1) && (px <= H_ACT) && (ln >= 1) && (ln <= V_ACT);
   endfunction

   // One clock: drive pulses, clock, advance model, compare all outputs.
   task automatic tick(input bit fs, input bit sr, input bit ac, input bit wh);
      int  px, ln;
      bit  e_br, e_iw;
      bit  sr_ok;
      frame_start = fs;
      shrink_req  = sr;
      arena_clr   = ac;
      wall_hit    = wh;
      px   = int'(pixel);
      ln   = int'(line);
      e_br = in_active(px, ln) && in_wall(px, ln, m_thk);
      e_iw = in_active(px, ln) && !in_wall(px, ln, m_thk);
      @(posedge clk);
      #1;
      if (rst) begin
         m_thk  = THK_MIN;
         m_pend = 1'b0;
         m_clrp = 1'b0;
         m_fcnt = 0;
         e_br   = 1'b0;
         e_iw   = 1'b0;
      end else begin
         sr_ok = sr && !ac;
         if (fs) begin
            if (m_clrp)      m_thk = THK_MIN;
            else if (m_pend) m_thk = (m_thk + THK_STEP > THK_MAX) ? THK_MAX : m_thk + THK_STEP;
            m_clrp = ac;
            m_pend = sr_ok;
         end else begin
            m_clrp = m_clrp || ac;
            m_pend = m_pend || sr_ok;
         end
         if (wh)                     m_fcnt = FLASH_N;
         else if (fs && m_fcnt > 0)  m_fcnt = m_fcnt - 1;
      end
      chk("bit_raster",    int'(bit_raster),    int'(e_br));
      chk("bit_raster_iw", int'(bit_raster_iw), int'(e_iw));
      chk("thk",           int'(thk),           m_thk);
      chk("at_max",        int'(at_max),        int'(m_thk == THK_MAX));
      chk("flash",         int'(flash),         int'(FL_EN && (m_fcnt != 0)));
      frame_start = 1'b0;
      shrink_req  = 1'b0;
      arena_clr   = 1'b0;
      wall_hit    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(0, 0, 0, 0);
      rst = 1'b0;
   endtask

   // ---------------- raster vector table (thk = 15) ----------------
   typedef struct {
      int px;
      int ln;
      bit br;
      bit iw;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{15,   200, 1'b1, 1'b0};
      tbl[1]  = '{16,   200, 1'b0, 1'b1};
      tbl[2]  = '{626,  240, 1'b1, 1'b0};
      tbl[3]  = '{0,    100, 1'b0, 1'b0};
      tbl[4]  = '{625,  240, 1'b0, 1'b1};
      tbl[5]  = '{640,  480, 1'b1, 1'b0};
      tbl[6]  = '{641,  100, 1'b0, 1'b0};
      tbl[7]  = '{100,  481, 1'b0, 1'b0};
      tbl[8]  = '{100,  15,  1'b1, 1'b0};
      tbl[9]  = '{100,  16,  1'b0, 1'b1};
      tbl[10] = '{100,  466, 1'b1, 1'b0};
      tbl[11] = '{100,  465, 1'b0, 1'b1};
      tbl[12] = '{1023, 511, 1'b0, 1'b0};
      tbl[13] = '{1,    0,   1'b0, 1'b0};

      rst = 1'b0; pixel = '0; line = '0;
      frame_start = 1'b0; shrink_req = 1'b0; arena_clr = 1'b0; wall_hit = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      pixel = 10'd15; line = 9'd200;
      do_reset();
      chk("rst_thk",    int'(thk),           THK_MIN);
      chk("rst_at_max", int'(at_max),        0);
      chk("rst_flash",  int'(flash),         0);
      chk("rst_raster", int'(bit_raster),    0);
      chk("rst_iw",     int'(bit_raster_iw), 0);

      // Raster table at default thickness, one-cycle latency
      for (int i = 0; i < 14; i++) begin
         pixel = 10'(tbl[i].px);
         line  = 9'(tbl[i].ln);
         tick(0, 0, 0, 0);
         chk("tbl_raster", int'(bit_raster),    int'(tbl[i].br));
         chk("tbl_iw",     int'(bit_raster_iw), int'(tbl[i].iw));
      end

      // Shrink with a dropped second request
      pixel = 10'd20; line = 9'd200;
      tick(0, 1, 0, 0);
      chk("pend_thk_unchanged", int'(thk), 15);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      chk("shrink_thk", int'(thk), 23);
      tick(0, 0, 0, 0);
      chk("shrink_raster_20", int'(bit_raster), 1);
      tick(1, 0, 0, 0);
      chk("no_accum_thk", int'(thk), 23);

      // Shrink arriving with frame_start is applied one frame later
      tick(1, 1, 0, 0);
      chk("same_cycle_thk", int'(thk), 23);
      tick(1, 0, 0, 0);
      chk("deferred_thk", int'(thk), 31);

      // Saturation
      do_reset();
      for (int i = 0; i < 14; i++) begin
         tick(0, 1, 0, 0);
         tick(1, 0, 0, 0);
      end
      chk("sat_thk",    int'(thk),    THK_MAX);
      chk("sat_at_max", int'(at_max), 1);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      chk("sat_hold_thk", int'(thk), THK_MAX);

      // Clear wins over same-cycle shrink
      tick(0, 1, 1, 0);
      chk("clr_wait_thk", int'(thk), THK_MAX);
      tick(1, 0, 0, 0);
      chk("clr_thk",    int'(thk),    THK_MIN);
      chk("clr_at_max", int'(at_max), 0);
      tick(1, 0, 0, 0);
      chk("clr_run_thk", int'(thk), THK_MIN);

      // Flash restart
      do_reset();
      tick(0, 0, 0, 1);
      chk("flash_rise", int'(flash), int'(FL_EN));
      for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
      chk("flash_5", int'(flash), int'(FL_EN));
      tick(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) tick(1, 0, 0, 0);
      chk("flash_7_after_restart", int'(flash), int'(FL_EN));
      tick(1, 0, 0, 0);
      chk("flash_fall", int'(flash), 0);
      tick(1, 0, 0, 1);
      chk("flash_load_beats_dec", int'(flash), int'(FL_EN));

      // Reset mid-flash with a shrink pending
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 0, 0);
         tick(1, 0, 0, 0);
      end
      chk("pre_rst_thk", int'(thk), 47);
      tick(0, 0, 0, 1);
      tick(0, 1, 0, 0);
      do_reset();
      chk("midrst_thk",    int'(thk),    THK_MIN);
      chk("midrst_flash",  int'(flash),  0);
      chk("midrst_at_max", int'(at_max), 0);
      tick(1, 0, 0, 0);
      chk("midrst_no_shrink", int'(thk), THK_MIN);

      // Randomized cycles against the model
      for (int i = 0; i < 4000; i++) begin
         pixel = 10'($urandom_range(0, 700));
         line  = 9'($urandom_range(0, 511));
         rst   = ($urandom_range(0, 399) == 0);
         tick($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0);
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arena_walls.md
# arena_walls

Parametrised playfield-border raster generator for the VGA ball game. It sits beside the sync generator and feeds the colour mux. Given the current pixel/line coordinate, it outputs a registered wall bit and a registered inside-wall bit. Beyond the fixed-border generator it replaces, it adds two features: a frame-synchronous "shrinking arena" (wall thickness grows on request, applied only at frame boundaries so nothing tears) and a wall-hit flash timer.

## Interface
Parameters:
- H_ACT, 640: active pixels per line; valid pixel range is 1..H_ACT.
- V_ACT, 480: active lines; valid line range is 1..V_ACT.
- X_W, 10: pixel coordinate width.
- Y_W, 9: line coordinate width.
- THK_MIN, 15: wall thickness after reset, in pixels.
- THK_MAX, 120: thickness ceiling. Must satisfy THK_MAX < V_ACT/2.
- THK_STEP, 8: thickness added per applied shrink.
- FLASH_FRAMES, 8: flash duration in frames (≥1).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  reset, synchronous, active-high.
- line  in  Y_W  current line coordinate.
- pixel  in  X_W  current pixel coordinate.
- frame_start  in  1  one-cycle pulse, once per frame, during blanking.
- shrink_req  in  1  one-cycle pulse requesting thickness += THK_STEP.
- arena_clr  in  1  one-cycle pulse returning thickness to THK_MIN.
- wall_hit  in  1  one-cycle pulse from ball logic when the ball touches the wall.
- bit_raster  out  1  coordinate is in the wall.
- bit_raster_iw  out  1  coordinate is in the active area inside the wall.
- flash  out  1  wall-colour invert request.
- at_max  out  1  current thickness equals THK_MAX.
- thk  out  X_W  current applied thickness.

## Operation
- Active region: 1 ≤ pixel ≤ H_ACT and 1 ≤ line ≤ V_ACT. Outside it, both bit_raster and bit_raster_iw are 0.
- Wall region (inside active) is any of:
  - pixel ≤ thk
  - pixel ≥ H_ACT−thk+1
  - line ≤ thk
  - line ≥ V_ACT−thk+1
- The border is symmetric, exactly thk wide on all four sides. Inside active, bit_raster_iw = ~bit_raster.
- Compare arithmetic is done at max(X_W, Y_W)+1 bits, with no wrap.
- Thickness FSM states:
  - RUN: no request pending. shrink_req → PEND.
  - PEND: a request is latched. On frame_start, thk ← min(thk+THK_STEP, THK_MAX), then → RUN.
- A shrink_req while in PEND is dropped; requests never accumulate.
- A shrink_req arriving in the same cycle as frame_start is latched, and applied at the following frame_start.
- When thk = THK_MAX, shrink_req is still accepted, but the applied value saturates at THK_MAX.
- arena_clr: at the next frame_start, thk ← THK_MIN and state → RUN. A pending shrink is discarded.
- arena_clr and shrink_req in the same cycle: arena_clr wins.
- at_max = (thk == THK_MAX), registered.
- Flash timer: wall_hit loads the counter with FLASH_FRAMES. Each frame_start decrements a nonzero counter. flash = (counter ≠ 0).
- A wall_hit during a flash restarts the count.
- wall_hit and frame_start in the same cycle: the load wins, with no decrement.

## Timing
- bit_raster and bit_raster_iw have 1-cycle latency from line/pixel.
- A thk change is visible on the output thk in the cycle after frame_start. Raster output uses the new value from that cycle on.
- flash rises the cycle after wall_hit. It falls the cycle after the FLASH_FRAMES-th subsequent frame_start.
- Reset (rst high at a clk edge) has priority over all inputs, including mid-frame or mid-flash. Reset values:
  - bit_raster=0, bit_raster_iw=0, flash=0, at_max=0
  - thk=THK_MIN, FSM=RUN, flash counter=0, pending clear=0

## Configuration
- ARENA_FLASH_EN defined: flash timer and flash output as above.
- ARENA_FLASH_EN undefined: no counter is synthesised, flash is tied to 0, and wall_hit is ignored.
- Raster and thickness behaviour are identical in both builds.

## Structure
- Shared package arena_pkg holds:
  - the default geometry constants (640, 480, 10, 9);
  - the thickness FSM state enum (RUN, PEND);
  - the function clog2 used for counter width.
- Sub-module arena_flash_timer: counter, load/decrement priority, and flash output. It is instantiated only under ARENA_FLASH_EN.
- Raster compare and FSM stay in the top module.

## Test plan
- Reset, defaults: (pixel, line) = (15, 200) → bit_raster=1. (16, 200) → bit_raster_iw=1. (626, 240) → bit_raster=1. (0, 100) → both 0. Each response appears 1 cycle later.
- shrink_req, then frame_start: thk goes 15→23 the cycle after frame_start. (20, 200) → bit_raster=1. A second shrink_req before frame_start does not make thk 31.
- Saturation: 14 applied shrinks from reset → thk=120 and at_max=1. Another shrink → thk stays 120.
- arena_clr and shrink_req in the same cycle, then frame_start → thk=15 and FSM=RUN. The next frame_start leaves thk=15.
- wall_hit → flash=1 next cycle. A wall_hit after 5 frame_starts restarts the count, so flash falls only after 8 further frame_starts. With ARENA_FLASH_EN undefined, flash stays 0.
- rst asserted mid-flash with thk=47 and a shrink pending → next cycle thk=15, flash=0, at_max=0, and no shrink at the following frame_start.
